// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests words from the memory controller
// and fills the IF/ID register, with stall buffering and delay-slot redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_if_stall,
  input  logic        id_if_selpcsource,
  input  logic [1:0]  id_if_selpctype,
  input  logic [31:0] id_if_pcimd2ext,
  input  logic [31:0] id_if_rega,
  input  logic [31:0] id_if_pcindex,
  output logic        if_mc_en,
  output logic [17:0] if_mc_addr,
  input  logic        mc_if_ready,
  input  logic [31:0] mc_if_data,
  output logic [31:0] if_id_instruc,
  output logic [31:0] if_id_nextpc,
  output logic        if_id_valid
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic        redirect_pending;
  logic [31:0] redirect_pc;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] new_pc;
  logic        live_rd;

  assign if_mc_en   = (state == FETCH);
  assign if_mc_addr = pc[19:2];
  assign pc_plus4   = pc + 32'd4;
  // A redirect only counts while the branch itself still sits in IF/ID.
  assign live_rd    = id_if_selpcsource & if_id_valid;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    target = id_if_pcimd2ext;
    unique case (id_if_selpctype)
      2'b00: target = id_if_pcimd2ext;
      2'b01: target = id_if_rega;
      2'b10: target = id_if_pcindex;
      2'b11: target = EXC_VECTOR;
    endcase
    target[1:0] = 2'b00;
  end

  always_comb begin
    new_pc = pc_plus4;
    if (redirect_pending)
      new_pc = redirect_pc;
    else if (live_rd)
      new_pc = target;
  end

  // NOTE: state registers use non-blocking assignments and an asynchronous
  // active-low reset, so all flops see pre-edge values and clear immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= FETCH;
      pc               <= RESET_PC;
      hold_buf         <= 32'h0;
      redirect_pending <= 1'b0;
      redirect_pc      <= 32'h0;
      if_id_instruc    <= NOP_WORD;
      if_id_nextpc     <= 32'h0;
      if_id_valid      <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (mc_if_ready) begin
            if (!ex_if_stall) begin
              if_id_instruc    <= mc_if_data;
              if_id_nextpc     <= pc_plus4;
              if_id_valid      <= 1'b1;
              pc               <= new_pc;
              redirect_pending <= 1'b0;
            end else begin
              // Word arrived during a stall: park it and stop requesting.
              hold_buf <= mc_if_data;
              state    <= HOLD;
            end
          end else if (!ex_if_stall) begin
            if_id_instruc <= NOP_WORD;
            if_id_valid   <= 1'b0;
            if (live_rd) begin
              redirect_pending <= 1'b1;
              redirect_pc      <= target;
            end
          end
        end
        HOLD: begin
          if (!ex_if_stall) begin
            if_id_instruc    <= hold_buf;
            if_id_nextpc     <= pc_plus4;
            if_id_valid      <= 1'b1;
            pc               <= new_pc;
            redirect_pending <= 1'b0;
            state            <= FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the fetch behaviour.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ex_if_stall = 1'b0;
  logic        id_if_selpcsource = 1'b0;
  logic [1:0]  id_if_selpctype = 2'b00;
  logic [31:0] id_if_pcimd2ext = 32'h0;
  logic [31:0] id_if_rega = 32'h0;
  logic [31:0] id_if_pcindex = 32'h0;
  logic        if_mc_en;
  logic [17:0] if_mc_addr;
  logic        mc_if_ready = 1'b0;
  logic [31:0] mc_if_data;
  logic [31:0] if_id_instruc;
  logic [31:0] if_id_nextpc;
  logic        if_id_valid;

  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: where the next fetch goes, whether a stalled word is
  // parked, what the decode stage currently sees, and any owed redirect.
  logic [31:0] m_pc, m_buf, m_ins, m_npc, m_rpc;
  logic        m_v, m_hold, m_red;

  fetch_stage dut (
    .clock(clock), .reset(reset), .ex_if_stall(ex_if_stall),
    .id_if_selpcsource(id_if_selpcsource), .id_if_selpctype(id_if_selpctype),
    .id_if_pcimd2ext(id_if_pcimd2ext), .id_if_rega(id_if_rega),
    .id_if_pcindex(id_if_pcindex), .if_mc_en(if_mc_en), .if_mc_addr(if_mc_addr),
    .mc_if_ready(mc_if_ready), .mc_if_data(mc_if_data),
    .if_id_instruc(if_id_instruc), .if_id_nextpc(if_id_nextpc),
    .if_id_valid(if_id_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [17:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], 16'h0} ^ {14'h0, a};
  endfunction

  assign mc_if_data = ovr_en ? ovr_data : mem_word(if_mc_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] decode_target(input logic [1:0] typ);
    logic [31:0] t;
    case (typ)
      2'b00:   t = id_if_pcimd2ext;
      2'b01:   t = id_if_rega;
      2'b10:   t = id_if_pcindex;
      default: t = 32'h0000_0080;
    endcase
    return t & ~32'h3;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_buf = 32'h0; m_ins = NOP; m_npc = 32'h0;
    m_rpc = 32'h0; m_v = 1'b0; m_hold = 1'b0; m_red = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".en"},    32'(if_mc_en),      32'(!m_hold));
    check({tag, ".addr"},  32'(if_mc_addr),    32'(m_pc[19:2]));
    check({tag, ".ins"},   if_id_instruc,      m_ins);
    check({tag, ".npc"},   if_id_nextpc,       m_npc);
    check({tag, ".valid"}, 32'(if_id_valid),   32'(m_v));
  endtask

  // One clock: apply inputs, predict the outcome, advance, compare.
  task automatic step(input string tag, input logic stall, input logic ready,
                      input logic sel, input logic [1:0] typ);
    logic [31:0] word, seq_pc;
    ex_if_stall       = stall;
    mc_if_ready       = ready;
    id_if_selpcsource = sel;
    id_if_selpctype   = typ;
    word   = m_hold ? m_buf : (ovr_en ? ovr_data : mem_word(m_pc[19:2]));
    seq_pc = m_pc + 32'd4;
    @(posedge clock);
    #1;
    if (stall) begin
      if (!m_hold && ready) begin
        m_hold = 1'b1;
        m_buf  = word;
      end
    end else if (m_hold || ready) begin
      m_ins = word;
      m_npc = seq_pc;
      if (m_red)             m_pc = m_rpc;
      else if (sel && m_v)   m_pc = decode_target(typ);
      else                   m_pc = seq_pc;
      m_v    = 1'b1;
      m_red  = 1'b0;
      m_hold = 1'b0;
    end else begin
      if (sel && m_v) begin
        m_red = 1'b1;
        m_rpc = decode_target(typ);
      end
      m_ins = NOP;
      m_v   = 1'b0;
    end
    check_all(tag);
  endtask

  task automatic quick_reset();
    reset = 1'b0;
    mc_if_ready = 1'b0;
    ex_if_stall = 1'b0;
    id_if_selpcsource = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    check_all("rst");
    reset = 1'b1;
  endtask

  initial begin
    model_reset();

    // Reset state, then straight-line fetch with memory always ready.
    repeat (2) @(posedge clock);
    #1;
    check("pre.ins", if_id_instruc, 32'h0);
    check("pre.npc", if_id_nextpc, 32'h0);
    check("pre.valid", 32'(if_id_valid), 32'h0);
    check("pre.addr", 32'(if_mc_addr), 32'h0);
    reset = 1'b1;
    step("seq0", 1'b0, 1'b1, 1'b0, 2'b00);
    check("seq0.A", if_id_instruc, mem_word(18'd0));
    check("seq0.pc4", if_id_nextpc, 32'd4);
    check("seq0.next", 32'(if_mc_addr), 32'd1);
    step("seq1", 1'b0, 1'b1, 1'b0, 2'b00);
    check("seq1.B", if_id_instruc, mem_word(18'd1));
    step("seq2", 1'b0, 1'b1, 1'b0, 2'b00);
    check("seq2.pc4", if_id_nextpc, 32'd12);

    // Branch at 0x10 to 0x40, zero wait states.
    id_if_pcimd2ext = 32'h0000_0040;
    step("br.a", 1'b0, 1'b1, 1'b0, 2'b00);
    step("br.b", 1'b0, 1'b1, 1'b0, 2'b00);
    step("br.ds", 1'b0, 1'b1, 1'b1, 2'b00);
    check("br.ds.npc", if_id_nextpc, 32'h18);
    check("br.tgt.addr", 32'(if_mc_addr), 32'h10);
    step("br.t", 1'b0, 1'b1, 1'b0, 2'b00);
    check("br.t.npc", if_id_nextpc, 32'h44);

    // Same branch, three wait states on the delay-slot fetch.
    quick_reset();
    repeat (5) step("ws.pre", 1'b0, 1'b1, 1'b0, 2'b00);
    step("ws.w0", 1'b0, 1'b0, 1'b1, 2'b00);
    check("ws.bubble", 32'(if_id_valid), 32'h0);
    step("ws.w1", 1'b0, 1'b0, 1'b1, 2'b01);
    step("ws.w2", 1'b0, 1'b0, 1'b0, 2'b00);
    check("ws.addr.ds", 32'(if_mc_addr), 32'h5);
    step("ws.ds", 1'b0, 1'b1, 1'b0, 2'b00);
    check("ws.ds.npc", if_id_nextpc, 32'h18);
    check("ws.tgt.addr", 32'(if_mc_addr), 32'h10);

    // Word returns during a 4-cycle stall.
    ovr_en = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    step("st.in", 1'b1, 1'b1, 1'b0, 2'b00);
    check("st.en", 32'(if_mc_en), 32'h0);
    ovr_data = 32'h1234_5678;
    repeat (3) step("st.hold", 1'b1, 1'b1, 1'b0, 2'b00);
    check("st.keep", if_id_nextpc, 32'h18);
    step("st.out", 1'b0, 1'b0, 1'b0, 2'b00);
    check("st.word", if_id_instruc, 32'hDEAD_BEEF);
    check("st.resume", 32'(if_mc_addr), 32'h11);
    ovr_en = 1'b0;

    // Register jump with unaligned rega, then exception vector.
    id_if_rega = 32'h0000_1003;
    step("jr", 1'b0, 1'b1, 1'b1, 2'b01);
    check("jr.addr", 32'(if_mc_addr), 32'h400);
    step("exc", 1'b0, 1'b1, 1'b1, 2'b11);
    check("exc.addr", 32'(if_mc_addr), 32'h20);

    // Reset during a wait, with ready arriving while reset is low.
    repeat (3) step("rw", 1'b0, 1'b0, 1'b0, 2'b00);
    #2;
    reset = 1'b0;
    mc_if_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    check_all("rw.rst");
    reset = 1'b1;
    step("rw.first", 1'b0, 1'b0, 1'b0, 2'b00);
    check("rw.addr0", 32'(if_mc_addr), 32'h0);
    check("rw.en", 32'(if_mc_en), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      id_if_pcimd2ext = $urandom;
      id_if_rega      = $urandom;
      id_if_pcindex   = $urandom;
      step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
